cordic_vectoring: RTL
=====================

Name: cordic_vectoring

Overview:
- Inverse of the rotation-mode CORDIC block: accepts a Cartesian vector (x, y), returns its phase in degrees and its gain-compensated magnitude.
- Fully pipelined vectoring-mode CORDIC with a valid-tagged stream. Accepts one sample per clock.
- Consumes the sin/cos format produced by the rotation block (signed, Q16 amplitude), so the two blocks can be chained for round-trip checking.

Parameters:
- ITER, 16: number of CORDIC micro-rotation stages.
- DW, 32: width of x_in, y_in, phase_out, mag_out.
- IW, 36: internal x/y datapath width; gives headroom for CORDIC gain growth of about 2.33.
- K_Q16, 39797: gain compensation constant, round(0.607253 * 2^16).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  x_in/y_in valid this cycle.
- x_in  in  DW  signed x (cos) component, Q16.
- y_in  in  DW  signed y (sin) component, Q16.
- out_valid  out  1  phase_out/mag_out valid this cycle.
- phase_out  out  DW  unsigned phase, degrees Q16, range [0, 360*2^16).
- mag_out  out  DW  unsigned magnitude, Q16, same scale as inputs.

Behaviour:
- Reset (asynchronous on rst_n low):
  - All pipeline valid bits are cleared.
  - out_valid, phase_out and mag_out are 0.
  - Reset mid-stream discards every in-flight sample; nothing emerges after release until new in_valid samples traverse the pipe.
- Latency: fixed ITER+2 = 18 cycles. out_valid(t+18) = in_valid(t). No backpressure, throughput 1/clk.
- Bubbles: in_valid low inserts a bubble that propagates unchanged. phase_out/mag_out update only on cycles with out_valid=1 and hold their last value otherwise.
- Stage 0, quadrant pre-rotation and registration:
  - Sign-extend inputs to IW.
  - If x_in < 0: x0 = -x_in, y0 = -y_in, z0 = 180*2^16.
  - Else: x0 = x_in, y0 = y_in, z0 = 0.
- Stages 1..ITER, i = 0..ITER-1, each registered:
  - If y_i >= 0: x += y>>>i, y -= x>>>i, z += A_i.
  - Else: x -= y>>>i, y += x>>>i, z -= A_i.
  - All shifts are arithmetic. The z path is signed 33 bits.
  - A_i = round(atan(2^-i)*180/pi*2^16) as a constant table. A_0..A_4 = 2949120, 1740967, 919879, 466945, 234379. A_15 = 115.
- Output stage, registered:
  - phase = z if z >= 0, else z + 360*2^16. Result always lies in [0, 23592960).
  - mag = (x_final * K_Q16) >>> 16, truncated to DW, unsigned.
- Special cases:
  - x_in = y_in = 0: phase_out = 0, mag_out = 0, exactly.
  - x_in = 0, y_in > 0: phase about 90°. x_in = 0, y_in < 0: phase about 270°.
  - y_in = 0, x_in < 0: phase about 180°.
- Supported input range: |x_in|, |y_in| <= 2^24. Outside this range, results are unspecified but must never be X. out_valid timing is unaffected.
- Accuracy within the supported range:
  - Phase error <= 330 LSB (about 0.005°), with wrap-around accounted for (359.999° vs 0°).
  - Magnitude error <= 2^-12 * true magnitude + 4 LSB.

Test Plan:
- Reset then single sample: x=65536, y=0. out_valid rises exactly 18 cycles after in_valid; phase within 330 of 0 (or of 23592960 after wrap); mag within 20 of 65536.
- Quadrants: (0,65536), (-65536,0), (0,-65536), (46341,46341) → phases about 5898240, 11796480, 17694720, 2949120 (±330); all mags about 65536.
- Round trip: drive the rotation CORDIC with phase 0..359 stepping 1 per clock; feed its cos/sin here. Recovered phase_out>>16 equals the original degree, tolerant of ±1 at the wrap. Continuous out_valid with no gaps.
- Bubbles: in_valid pattern 1,0,1,1,0 → identical out_valid pattern 18 cycles later; outputs hold during the 0 slots.
- Zero vector and reset mid-stream: (0,0) → phase 0, mag 0 exactly. Pulse rst_n low while 10 samples are in flight → out_valid=0 and outputs 0 immediately; no stale samples emerge after release.
- Large amplitude: x=-16777216, y=-16777216 → phase about 225° (14745600 ±330), mag about 23726566 within tolerance; no X on any output.

Source files
------------

// File: rtl/cordic_vectoring.sv
// cordic_vectoring: fully pipelined vectoring-mode CORDIC.
// Converts a Cartesian vector (x, y) in signed Q16 into its phase, in
// degrees Q16 over [0, 360), and its gain-compensated magnitude, in Q16.
// Accepts one sample per clock. Latency is ITER+2 cycles. No backpressure.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset; clears the pipe and the outputs
//   in_valid  x_in/y_in valid this cycle
//   x_in      signed x (cos) component, Q16
//   y_in      signed y (sin) component, Q16
//   out_valid phase_out/mag_out valid this cycle
//   phase_out unsigned phase, degrees Q16, [0, 360*2^16)
//   mag_out   unsigned magnitude, Q16; holds its last value between valid cycles
module cordic_vectoring #(
  parameter int ITER  = 16,
  parameter int DW    = 32,
  parameter int IW    = 36,
  parameter int K_Q16 = 39797
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] x_in,
  input  logic [DW-1:0] y_in,
  output logic          out_valid,
  output logic [DW-1:0] phase_out,
  output logic [DW-1:0] mag_out
);

  localparam int ZW = 33;
  localparam int PW = IW + 18;
  localparam logic signed [ZW-1:0] Z180 = 33'sd11796480;
  localparam logic signed [ZW-1:0] Z360 = 33'sd23592960;
  localparam logic signed [PW-1:0] K_S  = PW'(K_Q16);

  // round(atan(2^-i) * 180/pi * 2^16)
  function automatic logic signed [ZW-1:0] atan_lut(input int unsigned i);
    case (i)
      0:       atan_lut = 33'sd2949120;
      1:       atan_lut = 33'sd1740967;
      2:       atan_lut = 33'sd919879;
      3:       atan_lut = 33'sd466945;
      4:       atan_lut = 33'sd234379;
      5:       atan_lut = 33'sd117304;
      6:       atan_lut = 33'sd58666;
      7:       atan_lut = 33'sd29335;
      8:       atan_lut = 33'sd14668;
      9:       atan_lut = 33'sd7334;
      10:      atan_lut = 33'sd3667;
      11:      atan_lut = 33'sd1833;
      12:      atan_lut = 33'sd917;
      13:      atan_lut = 33'sd458;
      14:      atan_lut = 33'sd229;
      15:      atan_lut = 33'sd115;
      default: atan_lut = '0;
    endcase
  endfunction

  logic signed [IW-1:0] xs [ITER+1];
  logic signed [IW-1:0] ys [ITER+1];
  logic signed [ZW-1:0] zs [ITER+1];
  logic                 vld  [ITER+1];
  // A zero vector would otherwise converge to the sum of the atan table,
  // so it is tagged at entry and forced to 0 at the output.
  logic                 zero [ITER+1];

  logic signed [IW-1:0] x_ext, y_ext;
  assign x_ext = IW'($signed(x_in));
  assign y_ext = IW'($signed(y_in));

  // Stage 0: fold the left half-plane onto the right one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld[0]  <= 1'b0;
      zero[0] <= 1'b0;
      xs[0]   <= '0;
      ys[0]   <= '0;
      zs[0]   <= '0;
    end else begin
      vld[0]  <= in_valid;
      zero[0] <= (x_in == '0) && (y_in == '0);
      if (x_in[DW-1]) begin
        xs[0] <= -x_ext;
        ys[0] <= -y_ext;
        zs[0] <= Z180;
      end else begin
        xs[0] <= x_ext;
        ys[0] <= y_ext;
        zs[0] <= '0;
      end
    end
  end

  for (genvar i = 0; i < ITER; i++) begin : g_stage
    localparam logic signed [ZW-1:0] A = atan_lut(i);
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld[i+1]  <= 1'b0;
        zero[i+1] <= 1'b0;
        xs[i+1]   <= '0;
        ys[i+1]   <= '0;
        zs[i+1]   <= '0;
      end else begin
        vld[i+1]  <= vld[i];
        zero[i+1] <= zero[i];
        if (!ys[i][IW-1]) begin
          xs[i+1] <= xs[i] + (ys[i] >>> i);
          ys[i+1] <= ys[i] - (xs[i] >>> i);
          zs[i+1] <= zs[i] + A;
        end else begin
          xs[i+1] <= xs[i] - (ys[i] >>> i);
          ys[i+1] <= ys[i] + (xs[i] >>> i);
          zs[i+1] <= zs[i] - A;
        end
      end
    end
  end

  logic signed [ZW-1:0] phase_w;
  logic signed [PW-1:0] prod_w;

  always_comb begin
    phase_w = zs[ITER];
    if (zs[ITER][ZW-1]) phase_w = zs[ITER] + Z360;
    prod_w = PW'(xs[ITER]) * K_S;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      phase_out <= '0;
      mag_out   <= '0;
    end else begin
      out_valid <= vld[ITER];
      if (vld[ITER]) begin
        if (zero[ITER]) begin
          phase_out <= '0;
          mag_out   <= '0;
        end else begin
          phase_out <= DW'(phase_w);
          mag_out   <= DW'(prod_w >>> 16);
        end
      end
    end
  end

endmodule
